// File: rtl/router_pkg.sv
// Shared router definitions: constant-function clog2, default widths and the output VC type.
package router_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    localparam int DEFAULT_FLIT_WIDTH   = 36;
    localparam int DEFAULT_CREDIT_DEPTH = 5;
    localparam int CREDIT_WIDTH         = clog2(DEFAULT_CREDIT_DEPTH + 1);

    typedef logic [0:0] vc_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping modulo N.
module rr_arbiter
    import router_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = (clog2(N) > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    // Scan offsets from the pointer; the first hit blocks all later candidates.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int i = 0; i < N; i++) begin
                grant[i] = grant[i] | (!any && req[i] && (i == (int'(ptr) + off) % N));
                any      = any | grant[i];
            end
        end
    end

endmodule

// File: rtl/vc_output_arbiter.sv
// Credit-aware round-robin output stage for one router port.
// Optional statistics counters are built when VC_ARB_STATS_EN is defined.
module vc_output_arbiter
    import router_pkg::*;
#(
    parameter  int NINPUTS      = 10,
    parameter  int NVCS         = 2,
    parameter  int FLIT_WIDTH   = DEFAULT_FLIT_WIDTH,
    parameter  int CREDIT_DEPTH = DEFAULT_CREDIT_DEPTH,
    localparam int LOG_NVCS     = (clog2(NVCS) > 1) ? clog2(NVCS) : 1,
    localparam int CW           = clog2(CREDIT_DEPTH + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [FLIT_WIDTH*NINPUTS-1:0]  flit_in,
    input  logic [NINPUTS-1:0]             flit_in_valid,
    input  logic [LOG_NVCS*NINPUTS-1:0]    flit_in_vc,
    output logic [NINPUTS-1:0]             flit_ack,
    output logic [FLIT_WIDTH-1:0]          flit_out,
    output logic [LOG_NVCS-1:0]            flit_out_vc,
    output logic                           flit_out_valid,
    input  logic                           dequeue,
    input  logic [LOG_NVCS-1:0]            credit_in_vc,
    input  logic                           credit_in_valid,
    output logic                           credit_ack,
    output logic                           error,
    output logic                           is_quiescent,
    output logic [31:0]                    stat_flits,
    output logic [31:0]                    stat_stalls
);

    localparam int            PW         = (clog2(NINPUTS) > 1) ? clog2(NINPUTS) : 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDIT_DEPTH);

    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  flit_out_valid_q, flit_out_valid_d;
    logic [FLIT_WIDTH-1:0] flit_out_q, flit_out_d;
    logic [LOG_NVCS-1:0]   flit_out_vc_q, flit_out_vc_d;
    logic                  error_q, error_d;
    logic [CW-1:0]         credit_q [NVCS];
    logic [CW-1:0]         credit_d [NVCS];

    logic [LOG_NVCS-1:0]   in_vc_s [NINPUTS];
    logic [NVCS-1:0]       has_credit_s, inc_s, dec_s;
    logic [NINPUTS-1:0]    req_s, grant_s;
    logic                  any_s, slot_free_s, fire_s;
    logic                  all_full_s, overflow_s, credit_bad_s;
    logic [PW-1:0]         gidx_s;
    logic [LOG_NVCS-1:0]   gvc_s;
    logic [FLIT_WIDTH-1:0] gflit_s;

    // Per-VC credit availability and the idle-credit condition.
    always_comb begin
        all_full_s = 1'b1;
        for (int v = 0; v < NVCS; v++) begin
            has_credit_s[v] = (credit_q[v] != '0);
            all_full_s      = all_full_s && (credit_q[v] == CREDIT_MAX);
        end
    end

    // Eligibility: valid, enabled, target VC in range and holding at least one credit.
    always_comb begin
        for (int i = 0; i < NINPUTS; i++) begin
            in_vc_s[i] = flit_in_vc[i*LOG_NVCS +: LOG_NVCS];
            req_s[i]   = enable && flit_in_valid[i] && (int'(in_vc_s[i]) < NVCS)
                         && has_credit_s[in_vc_s[i]];
        end
    end

    rr_arbiter #(.N(NINPUTS)) u_rr (
        .req   (req_s),
        .ptr   (ptr_q),
        .grant (grant_s),
        .any   (any_s)
    );

    assign slot_free_s = !flit_out_valid_q || dequeue;
    assign fire_s      = slot_free_s && any_s;
    assign flit_ack    = slot_free_s ? grant_s : '0;

    // One-hot grant to index, VC and payload via AND-OR muxing.
    always_comb begin
        gidx_s  = '0;
        gvc_s   = '0;
        gflit_s = '0;
        for (int i = 0; i < NINPUTS; i++) begin
            gidx_s  = gidx_s | (grant_s[i] ? PW'(i) : '0);
            gvc_s   = gvc_s | ({LOG_NVCS{grant_s[i]}} & in_vc_s[i]);
            gflit_s = gflit_s | ({FLIT_WIDTH{grant_s[i]}} & flit_in[i*FLIT_WIDTH +: FLIT_WIDTH]);
        end
    end

    // Output slot and round-robin pointer next state.
    always_comb begin
        ptr_d            = ptr_q;
        flit_out_valid_d = flit_out_valid_q;
        flit_out_d       = flit_out_q;
        flit_out_vc_d    = flit_out_vc_q;
        if (fire_s) begin
            ptr_d            = (gidx_s == PW'(NINPUTS - 1)) ? '0 : gidx_s + PW'(1);
            flit_out_valid_d = 1'b1;
            flit_out_d       = gflit_s;
            flit_out_vc_d    = gvc_s;
        end else if (dequeue) begin
            flit_out_valid_d = 1'b0;
        end else begin
            flit_out_valid_d = flit_out_valid_q;
        end
    end

    // Credit consume/return strobes per VC.
    always_comb begin
        for (int v = 0; v < NVCS; v++) begin
            inc_s[v] = credit_in_valid && (credit_in_vc == LOG_NVCS'(v));
            dec_s[v] = fire_s && (gvc_s == LOG_NVCS'(v));
        end
    end

    // Counter update; a simultaneous grant and return on one VC cancel out.
    always_comb begin
        overflow_s = 1'b0;
        for (int v = 0; v < NVCS; v++) begin
            credit_d[v] = credit_q[v];
            if (inc_s[v] && !dec_s[v]) begin
                if (credit_q[v] == CREDIT_MAX) begin
                    overflow_s = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CW'(1);
                end
            end else if (dec_s[v] && !inc_s[v]) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end else begin
                credit_d[v] = credit_q[v];
            end
        end
    end

    assign credit_bad_s = credit_in_valid && (int'(credit_in_vc) >= NVCS);
    assign error_d      = error_q || overflow_s || credit_bad_s;

    // State registers; reset drops any in-flight flit and refills all credits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q            <= '0;
            flit_out_valid_q <= 1'b0;
            flit_out_q       <= '0;
            flit_out_vc_q    <= '0;
            error_q          <= 1'b0;
            for (int v = 0; v < NVCS; v++) begin
                credit_q[v] <= CREDIT_MAX;
            end
        end else begin
            ptr_q            <= ptr_d;
            flit_out_valid_q <= flit_out_valid_d;
            flit_out_q       <= flit_out_d;
            flit_out_vc_q    <= flit_out_vc_d;
            error_q          <= error_d;
            for (int v = 0; v < NVCS; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    assign flit_out       = flit_out_q;
    assign flit_out_vc    = flit_out_vc_q;
    assign flit_out_valid = flit_out_valid_q;
    assign credit_ack     = credit_in_valid;
    assign error          = error_q;
    assign is_quiescent   = !flit_out_valid_q && !(|flit_in_valid) && all_full_s;

`ifdef VC_ARB_STATS_EN
    logic [31:0] stat_flits_q, stat_flits_d;
    logic [31:0] stat_stalls_q, stat_stalls_d;

    // A stall is a cycle with a valid, enabled request that produced no grant.
    always_comb begin
        stat_flits_d  = stat_flits_q + (fire_s ? 32'd1 : 32'd0);
        stat_stalls_d = stat_stalls_q
                        + (((|flit_in_valid) && enable && !fire_s) ? 32'd1 : 32'd0);
    end

    // Wrapping statistics counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_flits_q  <= 32'd0;
            stat_stalls_q <= 32'd0;
        end else begin
            stat_flits_q  <= stat_flits_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_flits  = stat_flits_q;
    assign stat_stalls = stat_stalls_q;
`else
    assign stat_flits  = 32'd0;
    assign stat_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Scoreboard bench for vc_output_arbiter: directed vectors push expected flits, a monitor pops them.
module tb_vc_output_arbiter;

    localparam int N  = 10;
    localparam int FW = 36;
    localparam int LV = 1;
`ifdef VC_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic [FW*N-1:0] flit_in;
    logic [N-1:0]    flit_in_valid;
    logic [LV*N-1:0] flit_in_vc;
    logic [N-1:0]    flit_ack;
    logic [FW-1:0]   flit_out;
    logic [LV-1:0]   flit_out_vc;
    logic            flit_out_valid;
    logic            dequeue;
    logic [LV-1:0]   credit_in_vc;
    logic            credit_in_valid;
    logic            credit_ack;
    logic            error;
    logic            is_quiescent;
    logic [31:0]     stat_flits;
    logic [31:0]     stat_stalls;

    int n_cmp = 0;
    int n_err = 0;
    int tag   = 0;
    logic [FW+LV-1:0] exp_q[$];

    always #5 clock = ~clock;

    vc_output_arbiter #(.NINPUTS(N), .NVCS(2), .FLIT_WIDTH(FW), .CREDIT_DEPTH(5)) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .flit_in         (flit_in),
        .flit_in_valid   (flit_in_valid),
        .flit_in_vc      (flit_in_vc),
        .flit_ack        (flit_ack),
        .flit_out        (flit_out),
        .flit_out_vc     (flit_out_vc),
        .flit_out_valid  (flit_out_valid),
        .dequeue         (dequeue),
        .credit_in_vc    (credit_in_vc),
        .credit_in_valid (credit_in_valid),
        .credit_ack      (credit_ack),
        .error           (error),
        .is_quiescent    (is_quiescent),
        .stat_flits      (stat_flits),
        .stat_stalls     (stat_stalls)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every flit consumed downstream must match the oldest expected flit.
    always @(negedge clock) begin
        if (reset && flit_out_valid && dequeue) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL monitor_unexpected: got flit %0h vc %0d expected none", flit_out, flit_out_vc);
            end else begin
                chk("flit_out", 64'({flit_out_vc, flit_out}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] vcs, input logic en,
                        input logic cv, input logic cvc, input logic [N-1:0] exp_ack,
                        input string name);
        @(posedge clock);
        #1;
        tag++;
        flit_in_valid   = v;
        enable          = en;
        credit_in_valid = cv;
        credit_in_vc    = cvc;
        for (int i = 0; i < N; i++) begin
            flit_in[i*FW +: FW] = {8'(tag), 28'(i)};
            flit_in_vc[i]       = vcs[i];
        end
        @(negedge clock);
        chk(name, 64'(flit_ack), 64'(exp_ack));
        chk("credit_ack", 64'(credit_ack), 64'(cv));
        for (int i = 0; i < N; i++) begin
            if (exp_ack[i]) exp_q.push_back({vcs[i], 8'(tag), 28'(i)});
        end
    endtask

    initial begin
        reset           = 1'b0;
        enable          = 1'b1;
        flit_in         = '0;
        flit_in_valid   = '0;
        flit_in_vc      = '0;
        dequeue         = 1'b1;
        credit_in_vc    = 1'b0;
        credit_in_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_valid", 64'(flit_out_valid), 64'd0);
        chk("rst_flit", 64'(flit_out), 64'd0);
        chk("rst_quiescent", 64'(is_quiescent), 64'd1);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_credit0", 64'(dut.credit_q[0]), 64'd5);
        chk("rst_credit1", 64'(dut.credit_q[1]), 64'd5);
        chk("rst_stats", 64'({stat_flits, stat_stalls}), 64'd0);

        // Round-robin 0,3,9 then wrap to 0; VC0 credit returned alongside each grant.
        step(10'h209, 10'h000, 1'b1, 1'b1, 1'b0, 10'h001, "rr_g0");
        step(10'h209, 10'h000, 1'b1, 1'b1, 1'b0, 10'h008, "rr_g3");
        step(10'h209, 10'h000, 1'b1, 1'b1, 1'b0, 10'h200, "rr_g9");
        step(10'h209, 10'h000, 1'b1, 1'b1, 1'b0, 10'h001, "rr_wrap0");
        step(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, "idle1");
        chk("rr_credit0", 64'(dut.credit_q[0]), 64'd5);

        // Credit exhaustion on VC0 from input 5, then one returned credit.
        for (int k = 0; k < 5; k++) step(10'h020, 10'h000, 1'b1, 1'b0, 1'b0, 10'h020, "cred_g");
        step(10'h020, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, "cred_stall");
        step(10'h020, 10'h000, 1'b1, 1'b1, 1'b0, 10'h000, "cred_ret_cycle");
        step(10'h020, 10'h000, 1'b1, 1'b0, 1'b0, 10'h020, "cred_g6");
        step(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, "idle2");
        chk("cred_empty0", 64'(dut.credit_q[0]), 64'd0);
        chk("cred_quiescent", 64'(is_quiescent), 64'd0);
        for (int k = 0; k < 5; k++) step(10'h000, 10'h000, 1'b1, 1'b1, 1'b0, 10'h000, "refill");
        step(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, "idle3");
        chk("refill_credit0", 64'(dut.credit_q[0]), 64'd5);
        chk("refill_error", 64'(error), 64'd0);
        chk("refill_quiescent", 64'(is_quiescent), 64'd1);

        // VC1: grant, then grant plus return in the same cycle.
        step(10'h004, 10'h004, 1'b1, 1'b0, 1'b0, 10'h004, "vc1_g");
        step(10'h004, 10'h004, 1'b1, 1'b1, 1'b1, 10'h004, "vc1_g_ret");
        step(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, "idle4");
        chk("vc1_net_zero", 64'(dut.credit_q[1]), 64'd4);
        chk("vc1_error", 64'(error), 64'd0);
        step(10'h000, 10'h000, 1'b1, 1'b1, 1'b1, 10'h000, "vc1_ret");

        // Overflow on a full VC0.
        step(10'h000, 10'h000, 1'b1, 1'b1, 1'b0, 10'h000, "ovf");
        step(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, "idle5");
        chk("ovf_error", 64'(error), 64'd1);
        chk("ovf_credit0", 64'(dut.credit_q[0]), 64'd5);
        chk("ovf_credit1", 64'(dut.credit_q[1]), 64'd5);
        step(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, "idle6");
        chk("ovf_sticky", 64'(error), 64'd1);
        chk("stat_flits", 64'(stat_flits), STATS ? 64'd12 : 64'd0);
        chk("stat_stalls", 64'(stat_stalls), STATS ? 64'd2 : 64'd0);

        // Enable low blocks grants and is not counted as a stall.
        step(10'h003, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, "en0_a");
        step(10'h003, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, "en0_b");
        chk("en0_valid", 64'(flit_out_valid), 64'd0);
        step(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, "idle7");
        chk("en0_stalls", 64'(stat_stalls), STATS ? 64'd2 : 64'd0);

        // Asynchronous reset with a flit held in the slot.
        dequeue = 1'b0;
        step(10'h010, 10'h000, 1'b1, 1'b0, 1'b0, 10'h010, "pre_rst");
        @(posedge clock);
        #1;
        flit_in_valid = '0;
        #2;
        chk("pre_rst_valid", 64'(flit_out_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(flit_out_valid), 64'd0);
        chk("rst_mid_flit", 64'(flit_out), 64'd0);
        chk("rst_mid_error", 64'(error), 64'd0);
        chk("rst_mid_stats", 64'({stat_flits, stat_stalls}), 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset   = 1'b1;
        dequeue = 1'b1;
        step(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, "post_rst");
        chk("post_rst_quiescent", 64'(is_quiescent), 64'd1);
        chk("post_rst_credit0", 64'(dut.credit_q[0]), 64'd5);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vc_output_arbiter.md
# vc_output_arbiter

Parametrised, credit-aware output stage for one router output port. It arbitrates round-robin among `NINPUTS` input-VC requestors and forwards one flit per cycle into a registered output slot. Per-output-VC credit counters gate forwarding and refill from downstream credit returns. It generalises the router's fixed single-output path to any input count, VC count and buffer depth, and adds quiescence and overflow-error reporting.

## Interface
Parameters:
- `NINPUTS`, 10: number of requesting input VCs.
- `NVCS`, 2: output virtual channels; `LOG_NVCS = max(1, clog2(NVCS))`.
- `FLIT_WIDTH`, 36: flit payload width.
- `CREDIT_DEPTH`, 5: downstream buffer slots per VC; counter width `CW = clog2(CREDIT_DEPTH+1)`.

Ports:
- `clock`, in, 1: single clock.
- `reset`, in, 1: one clock; reset is asynchronous and active-low.
- `enable`, in, 1: high permits new grants.
- `flit_in`, in, `FLIT_WIDTH*NINPUTS`: concatenated input flits; input i in slice i.
- `flit_in_valid`, in, `NINPUTS`: request per input.
- `flit_in_vc`, in, `LOG_NVCS*NINPUTS`: target output VC per input.
- `flit_ack`, out, `NINPUTS`: one-hot grant, combinational, same cycle as transfer.
- `flit_out`, out, `FLIT_WIDTH`: registered output flit.
- `flit_out_vc`, out, `LOG_NVCS`: VC of `flit_out`.
- `flit_out_valid`, out, 1: output slot occupied.
- `dequeue`, in, 1: downstream consumes `flit_out` this cycle.
- `credit_in_vc`, in, `LOG_NVCS`: VC receiving a returned credit.
- `credit_in_valid`, in, 1: credit return strobe.
- `credit_ack`, out, 1: equals `credit_in_valid`; always accepted.
- `error`, out, 1: sticky credit-overflow flag.
- `is_quiescent`, out, 1: idle indicator.
- `stat_flits`, out, 32: forwarded-flit count.
- `stat_stalls`, out, 32: credit-stall cycle count.

## Operation
- Reset values: `flit_out_valid=0`, `flit_out=0`, `flit_out_vc=0`, `error=0`, `stat_*=0`, RR pointer 0, every credit counter `CREDIT_DEPTH`.
- Eligibility of input i: `flit_in_valid[i]`, `credit[vc_i] > 0`, and `enable`.
- Slot free when `!flit_out_valid || dequeue`.
- Grant: when the slot is free, choose the first eligible input at or after the pointer, with wrap-around modulo `NINPUTS`. Assert `flit_ack[i]`. Load the flit and VC into the slot at the next edge. Set the pointer to `(i+1) mod NINPUTS`.
- No grant: the pointer holds. The slot clears on `dequeue`.
- Credits: a grant decrements `credit[vc]`. `credit_in_valid` increments `credit[credit_in_vc]`. If both hit the same VC in one cycle, the net change is 0.
- Overflow: an increment that would exceed `CREDIT_DEPTH` leaves the counter saturated and sets `error`. `error` clears only on reset.
- `credit_in_vc >= NVCS` is ignored and sets `error`.
- `enable` low blocks grants only. Credits and dequeue still operate.
- `is_quiescent = !flit_out_valid && !(|flit_in_valid) && all credits == CREDIT_DEPTH`.

## Timing
- `flit_ack` to `flit_out_valid`: 1 cycle.
- Full throughput: with `dequeue` held high, one flit per cycle.
- Credit-gated grant: the first possible grant using a returned credit is the cycle after `credit_in_valid`, because counters are registered.
- Reset asserted mid-operation: the in-flight slot is dropped and all state returns to reset values asynchronously.

## Configuration
- `VC_ARB_STATS_EN` defined:
  - `stat_flits` increments on each grant.
  - `stat_stalls` increments each cycle in which some input is valid and `enable` is high but no grant occurs.
  - Both counters wrap at 2^32.
- `VC_ARB_STATS_EN` undefined: the counters are not built, and both ports are constant 0.

## Structure
- Shared package `router_pkg`: `clog2` function, `FLIT_WIDTH`/`CREDIT_WIDTH` defaults, and a `vc_t` typedef.
- Sub-module `rr_arbiter`: parametrised `N`, request vector plus pointer in, one-hot grant plus `any` out, purely combinational. The parent owns the pointer register.

## Test plan
- Reset then idle: `is_quiescent=1`, all credits 5, `flit_out_valid=0`.
- Inputs 0, 3 and 9 valid to VC0, `dequeue=1`: grants in order 0, 3, 9, 0. Pointer wraps from 9 to 0.
- Six back-to-back flits to VC0 with no credit return: 5 grants, then a stall. `stat_stalls` increments when enabled. One `credit_in_valid` to VC0 produces the sixth grant the following cycle.
- Grant to VC1 and credit return to VC1 in the same cycle: the VC1 counter is unchanged.
- Credit return to VC0 while it holds 5 credits: `error=1` and sticky; counter stays 5.
- `enable=0` with valid inputs: no `flit_ack`. Asserting reset mid-stream: `flit_out_valid` drops immediately.
